// File: rtl/stream_serializer_pkg.sv
// stream_serializer_pkg: shared state encoding and width derivation for the serializer family.
package stream_serializer_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
    function automatic int iwidth(input int owidth, input int logratio);
        return owidth << logratio;
    endfunction
endpackage

// File: rtl/stream_serializer_if.sv
// stream_serializer_if: wide valid/ready input side and narrow valid/ready/last output side.
interface stream_serializer_if #(
    parameter int OWIDTH   = 8,
    parameter int LOGRATIO = 2
);
    import stream_serializer_pkg::*;
    localparam int IWIDTH = iwidth(OWIDTH, LOGRATIO);
    logic              in_val;
    logic [IWIDTH-1:0] in_data;
    logic              in_rdy;
    logic              out_val;
    logic [OWIDTH-1:0] out_data;
    logic              out_last;
    logic              out_rdy;
    modport master (output in_val, in_data, out_rdy, input in_rdy, out_val, out_data, out_last);
    modport slave  (input in_val, in_data, out_rdy, output in_rdy, out_val, out_data, out_last);
endinterface

// File: rtl/stream_beat_counter.sv
// stream_beat_counter: beat index within a word, saturating at RATIO-1 with a last flag.
module stream_beat_counter #(
    parameter int LOGRATIO = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   inc_i,
    input  logic                                   clr_i,
    output logic [(LOGRATIO > 0 ? LOGRATIO : 1)-1:0] cnt_o,
    output logic                                   last_o
);
    localparam int CW = LOGRATIO > 0 ? LOGRATIO : 1;
    localparam logic [CW-1:0] MAX = CW'((1 << LOGRATIO) - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = clr_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
        cnt_o  = cnt_q;
        last_o = cnt_q == MAX;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/stream_serializer.sv
// stream_serializer: splits each wide FIFO word into RATIO narrow beats, LSB beat first.
// Define SERIALIZER_MSB_FIRST_EN to emit the MSB beat first instead.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int OWIDTH   = 8,
    parameter int LOGRATIO = 2
) (
    input logic                clk,
    input logic                reset_n,
    stream_serializer_if.slave s
);
    localparam int IWIDTH = iwidth(OWIDTH, LOGRATIO);
    localparam int RATIO  = 1 << LOGRATIO;
    localparam int CW     = LOGRATIO > 0 ? LOGRATIO : 1;
    state_t            state_q, state_d;
    logic [IWIDTH-1:0] word_q, word_d, word_sh;
    logic [CW-1:0]     cnt, sel;
    logic              last, in_fire, out_fire, wrap, inc, clr;
    stream_beat_counter #(.LOGRATIO(LOGRATIO)) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_i  (inc),
        .clr_i  (clr),
        .cnt_o  (cnt),
        .last_o (last)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    // in_fire on the last beat reloads the word and stays in SEND: zero-bubble streaming
    always_comb begin
        state_d = in_fire ? S_SEND : wrap ? S_IDLE : state_q;
        word_d  = in_fire ? s.in_data : word_q;
        inc     = out_fire & ~last;
        clr     = in_fire | wrap;
    end
    always_comb begin
        s.out_val  = state_q == S_SEND;
        s.out_last = s.out_val & last;
        out_fire   = s.out_val & s.out_rdy;
        wrap       = out_fire & last;
        s.in_rdy   = (state_q == S_IDLE) | wrap;
        in_fire    = s.in_val & s.in_rdy;
`ifdef SERIALIZER_MSB_FIRST_EN
        sel        = CW'(RATIO - 1) - cnt;
`else
        sel        = cnt;
`endif
        word_sh    = word_q >> (sel * OWIDTH);
        s.out_data = s.out_val ? word_sh[OWIDTH-1:0] : '0;
    end
endmodule
